// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler cluster.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int SW_DEF   = 24;
  localparam int NREQ_DEF = 4;

  // Width of a requester index; ceil(log2(n)) for n >= 2.
  function automatic int idw_for(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cmult.sv
// Full-width unsigned SW x SW combinational multiplier.
module cmult #(
  parameter int SW = 24
) (
  input  logic [SW-1:0]   i_a,
  input  logic [SW-1:0]   i_b,
  output logic [2*SW-1:0] o_p
);

  assign o_p = {{SW{1'b0}}, i_a} * {{SW{1'b0}}, i_b};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int k = 0; k < N; k++) begin
      int          j;
      logic [PW-1:0] jx;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jx = PW'(j);
      if (!any && req[jx]) begin
        any            = 1'b1;
        gnt_idx        = jx;
        gnt_onehot[jx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one cmult among NREQ valid/ready requesters; result held, tagged, until accepted.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int SW   = SW_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = idw_for(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*SW-1:0]   req_a_i,
  input  logic [NREQ*SW-1:0]   req_b_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [IDW-1:0]       res_id_o,
  output logic [2*SW-1:0]      res_data_o
);

  if (IDW != idw_for(NREQ) || NREQ < 2 || NREQ > 16) begin : g_cfg_err
    $error("mult_share_arb: NREQ must be 2..16 and IDW must equal clog2(NREQ)");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    w_ptr_nxt;

  logic [NREQ-1:0]   w_gnt_onehot;
  logic [IDW-1:0]    w_gnt_idx;
  logic              w_any;

  logic              w_accept;
  logic              w_load_res;
  logic              w_release;

  logic [SW-1:0]     w_a_sel;
  logic [SW-1:0]     w_b_sel;
  logic [2*SW-1:0]   w_prod;

  logic [SW-1:0]     r_a_p0;
  logic [SW-1:0]     r_b_p0;
  logic [IDW-1:0]    r_id_p0;

  logic              r_vld_p1;
  logic [IDW-1:0]    r_id_p1;
  logic [2*SW-1:0]   r_data_p1;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req        (req_valid_i),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_onehot[i]) begin
        w_a_sel = req_a_i[i*SW +: SW];
        w_b_sel = req_b_i[i*SW +: SW];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_res  = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        w_load_res  = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (res_ready_i) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A grant in a reset cycle would be lost, so it is never offered.
    if (rst) w_accept = 1'b0;
  end

  assign req_ready_o = w_accept ? w_gnt_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Stage p0: granted operands and owner tag captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_id_p0  <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_ptr_nxt;
      r_a_p0   <= w_a_sel;
      r_b_p0   <= w_b_sel;
      r_id_p0  <= w_gnt_idx;
    end
  end

  cmult #(.SW(SW)) u_cmult (
    .i_a (r_a_p0),
    .i_b (r_b_p0),
    .o_p (w_prod)
  );

  // Stage p1: registered product held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_id_p1   <= '0;
      r_data_p1 <= '0;
    end else if (w_load_res) begin
      r_vld_p1  <= 1'b1;
      r_id_p1   <= r_id_p0;
      r_data_p1 <= w_prod;
    end else if (w_release) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign res_valid_o = r_vld_p1;
  assign res_id_o    = r_id_p1;
  assign res_data_o  = r_data_p1;

  a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready_o));

  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (res_valid_o && !res_ready_i) |=> (res_valid_o && $stable(res_data_o) && $stable(res_id_o)));

  a_no_grant_busy : assert property (@(posedge clk) res_valid_o |-> (req_ready_o == '0));

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed vectors, corner sequences and randomized traffic against a transaction model.
module tb_mult_share_arb;

  localparam int SW   = 24;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SW-1:0]   req_a;
  logic [NREQ*SW-1:0]   req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [IDW-1:0]       res_id;
  logic [2*SW-1:0]      res_data;

  mult_share_arb #(.SW(SW), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_id_o    (res_id),
    .res_data_o  (res_data)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction-level model: one operation at most in flight, either computing or waiting for the consumer.
  int              m_ptr  = 0;
  bit              m_mul  = 1'b0;
  bit              m_pend = 1'b0;
  int              m_id   = 0;
  longint unsigned m_prod = 0;
  int              last_g = -1;
  int              cyc    = 0;

  int              acc_id[$];
  longint unsigned acc_data[$];
  int              acc_cyc[$];

  typedef struct {
    int              k;
    logic [SW-1:0]   a;
    logic [SW-1:0]   b;
    logic [2*SW-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [SW-1:0] rand_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      default: return SW'($urandom);
    endcase
  endfunction

  task automatic set_req(input int k, input logic [SW-1:0] a, input logic [SW-1:0] b);
    req_valid[k]       = 1'b1;
    req_a[k*SW +: SW]  = a;
    req_b[k*SW +: SW]  = b;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven; returns 1 unit after the next edge.
  task automatic cycle();
    int              g;
    logic [NREQ-1:0] exp_rdy;
    longint unsigned prod;
    #1;
    g = -1;
    if (!rst && !m_mul && !m_pend) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    prod    = 0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      prod = 64'(req_a[g*SW +: SW]) * 64'(req_b[g*SW +: SW]);
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("res_valid", 64'(res_valid), 64'(m_pend));
    chk("res_data_known", 64'($isunknown(res_data)), 64'(0));
    if (m_pend) begin
      chk("res_id", 64'(res_id), 64'(m_id));
      chk("res_data", 64'(res_data), m_prod);
    end
    if (res_valid && res_ready) begin
      acc_id.push_back(int'(res_id));
      acc_data.push_back(64'(res_data));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_ptr  = 0;
      m_mul  = 1'b0;
      m_pend = 1'b0;
    end else if (m_mul) begin
      m_mul  = 1'b0;
      m_pend = 1'b1;
    end else if (m_pend) begin
      if (res_ready) m_pend = 1'b0;
    end else if (g >= 0) begin
      m_mul  = 1'b1;
      m_id   = g;
      m_prod = prod;
      m_ptr  = (g + 1) % NREQ;
    end
    last_g = rst ? -1 : g;
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    rst       = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{k: 2, a: 24'd1000,     b: 24'd3000,     exp: 48'd3000000};
    vecs[1] = '{k: 0, a: 24'hFFFFFF,   b: 24'hFFFFFF,   exp: 48'hFFFFFE000001};
    vecs[2] = '{k: 1, a: 24'd0,        b: 24'h123456,   exp: 48'd0};
    vecs[3] = '{k: 3, a: 24'h123456,   b: 24'd0,        exp: 48'd0};
    vecs[4] = '{k: 3, a: 24'hFFFFFF,   b: 24'd1,        exp: 48'hFFFFFF};
    vecs[5] = '{k: 1, a: 24'd4096,     b: 24'd4096,     exp: 48'd16777216};

    // Reset with every requester asserting: nothing may be granted.
    rst       = 1'b1;
    res_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, SW'(i + 1), SW'(16));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_res_id", 64'(res_id), 64'(0));

    // Release into continuous all-valid traffic.
    rst = 1'b0;
    acc_id.delete();
    acc_data.delete();
    acc_cyc.delete();
    #1;
    chk("first_grant", 64'(req_ready), 64'(4'b0001));
    for (int i = 0; i < 15; i++) cycle();
    chk("rr_count", 64'(acc_id.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++) begin
      chk("rr_id", 64'(acc_id.size() > i ? acc_id[i] : -1), 64'(i % 4));
      chk("rr_data", acc_data.size() > i ? acc_data[i] : 64'hDEAD, 64'(16 * (i % 4 + 1)));
      if (i > 0) chk("rr_interval", 64'(acc_cyc.size() > i ? acc_cyc[i] - acc_cyc[i-1] : -1), 64'(3));
    end
    drain();

    // Backpressure: a result waits ten cycles while another requester is pending.
    set_req(1, 24'd5, 24'd7);
    res_ready = 1'b0;
    #1;
    chk("bp_grant", 64'(req_ready), 64'(4'b0010));
    cycle();
    req_valid[1] = 1'b0;
    set_req(3, 24'd2, 24'd3);
    begin
      int waited;
      waited = 0;
      while (!res_valid && waited < 10) begin
        cycle();
        waited++;
      end
      chk("bp_result_latency", 64'(waited), 64'(1));
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(res_valid), 64'(1));
      chk("bp_id", 64'(res_id), 64'(1));
      chk("bp_data", 64'(res_data), 64'(35));
      chk("bp_no_ready", 64'(req_ready), 64'(0));
      cycle();
    end
    res_ready = 1'b1;
    cycle();
    #1;
    chk("bp_next_grant", 64'(req_ready), 64'(4'b1000));
    cycle();
    req_valid[3] = 1'b0;
    drain();

    // Directed vectors, one requester at a time.
    for (int v = 0; v < 6; v++) begin
      req_valid = '0;
      res_ready = 1'b1;
      set_req(vecs[v].k, vecs[v].a, vecs[v].b);
      #1;
      chk("vec_ready", 64'(req_ready), 64'(1 << vecs[v].k));
      cycle();
      req_valid = '0;
      cycle();
      chk("vec_valid", 64'(res_valid), 64'(1));
      chk("vec_id", 64'(res_id), 64'(vecs[v].k));
      chk("vec_data", 64'(res_data), 64'(vecs[v].exp));
      cycle();
      chk("vec_release", 64'(res_valid), 64'(0));
    end
    drain();

    // Reset during MUL: work is dropped and the pointer restarts at 0.
    set_req(2, 24'd9, 24'd9);
    #1;
    chk("mr_grant", 64'(req_ready), 64'(4'b0100));
    cycle();
    rst = 1'b1;
    set_req(3, 24'd11, 24'd11);
    #1;
    chk("mr_rst_no_ready", 64'(req_ready), 64'(0));
    cycle();
    rst = 1'b0;
    #1;
    chk("mr_no_result", 64'(res_valid), 64'(0));
    chk("mr_regrant", 64'(req_ready), 64'(4'b0100));
    cycle();
    req_valid[2] = 1'b0;
    cycle();
    chk("mr_result", 64'(res_data), 64'(81));
    cycle();
    req_valid[3] = 1'b0;
    drain();

    // Reset during HOLD.
    set_req(0, 24'd3, 24'd4);
    res_ready = 1'b0;
    cycle();
    req_valid = '0;
    cycle();
    chk("hr_pending", 64'(res_valid), 64'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("hr_dropped", 64'(res_valid), 64'(0));
    drain();

    // Randomized traffic obeying the requester hold rules.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] && $urandom_range(2) == 0) set_req(k, rand_op(), rand_op());
      end
      res_ready = ($urandom_range(9) < 7);
      rst       = ($urandom_range(199) == 0);
      cycle();
      if (last_g >= 0 && $urandom_range(1) == 0) req_valid[last_g] = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one combinational SW x SW unsigned multiplier (cmult) among NREQ requesters.
- Uses per-requester valid/ready handshakes and a round-robin grant.
- Registers the granted operands, runs one multiply, then holds a registered, tagged result until the consumer accepts it.
- Sits between the approximate-arithmetic clients and the shared multiplier; it is the only instantiator of cmult in the cluster.

Parameters:
- SW, 24, operand width in bits; product is 2*SW.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester-ID width; must equal clog2(NREQ) (elaboration-time check).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  NREQ  request valid, one bit per requester.
- req_ready_o  out  NREQ  request accepted this cycle; one-hot or zero.
- req_a_i  in  NREQ*SW  operand A; requester i occupies bits [i*SW +: SW].
- req_b_i  in  NREQ*SW  operand B, same packing as req_a_i.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_id_o  out  IDW  index of the requester that owns the result.
- res_data_o  out  2*SW  product A*B, unsigned, full width, no truncation.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, rr_ptr=0, res_valid_o=0, res_id_o=0, res_data_o=0.
  - Operand registers are cleared to 0.
  - req_ready_o=0 while rst is high.
- FSM states: IDLE, MUL, HOLD.
- IDLE:
  - If any req_valid_i bit is set, grant the first set bit found searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - req_ready_o[g]=1 combinationally in that cycle. This is the only path from req_valid_i to an output.
  - At the clock edge: latch a_q=A[g], b_q=B[g], id_q=g; set rr_ptr=(g+1) mod NREQ; go to MUL.
  - If no request is valid: stay in IDLE; rr_ptr is unchanged.
- MUL:
  - cmult computes a_q*b_q.
  - At the clock edge: res_data_o is loaded with the product, res_id_o with id_q, res_valid_o is set to 1; go to HOLD.
  - req_ready_o is all zero.
- HOLD:
  - res_valid_o=1; res_data_o and res_id_o are held stable.
  - When res_ready_i=1: at the clock edge res_valid_o goes to 0 and the FSM goes to IDLE.
  - No new request is accepted in the same cycle.
  - While res_ready_i=0 the FSM stays in HOLD indefinitely.
- Latency and throughput:
  - Acceptance at edge N gives res_valid_o=1 after edge N+1, i.e. 2 cycles from handshake to result.
  - Best-case issue interval is 3 cycles (IDLE, MUL, HOLD with immediate ready).
- Requester rules:
  - Once raised, req_valid_i[i] and its operands stay stable until req_ready_o[i]=1.
  - Non-granted requesters wait; fairness means each waits at most NREQ-1 other grants.
- Result data: res_data_o is don't-care when res_valid_o=0, but is never X after reset.
- Boundary conditions:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - Only requester k valid: it is granted every interval regardless of rr_ptr.
  - rr_ptr=NREQ-1 wraps to 0.
  - Operands all ones: product (2^SW-1)^2, exact, no overflow.
  - Zero operand: product 0.
  - rst asserted in MUL or HOLD: the in-flight transaction is discarded with no result. The next cycle is IDLE with res_valid_o=0.
  - rst asserted in the same cycle as a grant: no grant occurs (req_ready_o=0).
- No combinational path from res_ready_i to any output.

Decomposition:
- Package mult_share_pkg holds:
  - the state enum (IDLE, MUL, HOLD);
  - localparam defaults SW_DEF=24, NREQ_DEF=4;
  - a function computing IDW from NREQ.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], ptr[clog2 N];
  - outputs gnt_onehot[N], gnt_idx, any.
  - Purely combinational; reused by other shared-operator schedulers.
- cmult is instantiated once with SW passed through.

Test Plan:
- Reset/idle: hold rst 3 cycles with all req_valid_i=1 -> req_ready_o=0, res_valid_o=0, res_data_o=0; first grant after release goes to requester 0.
- Single request: requester 2 with A=24'd1000, B=24'd3000 -> req_ready_o=4'b0100 in 1 cycle; 2 cycles later res_valid_o=1, res_id_o=2, res_data_o=48'd3000000.
- Round-robin: all 4 valid continuously with A=i+1, B=16, res_ready_i=1 -> ids 0,1,2,3,0 in order, data 16,32,48,64,16, one result every 3 cycles.
- Backpressure: res_ready_i=0 for 10 cycles while a result is pending -> res_data_o and res_id_o stable, no req_ready_o asserted; release -> IDLE, next grant the following cycle.
- Extremes: A=B=24'hFFFFFF -> res_data_o=48'hFFFFFE000001; A=0, B=24'h123456 -> 0.
- Mid-operation reset: assert rst in the MUL cycle -> no res_valid_o pulse, rr_ptr=0, pending requester re-granted after reset.
